// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first; done pulses WIDTH+1 cycles after the start edge.
// No backpressure: start is only accepted in IDLE, and a start that arrives while busy is dropped, not queued.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_btn,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]   bit_cnt;
  logic            carry;
  logic            c_msb_in;

  logic            s_bit;
  logic            c_next;

  // The single full-adder cell shared by every bit position.
  assign s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));

  always_ff @(posedge clk) begin
    if (!rst_btn) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      bit_cnt  <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1, so the +1 rides in on the carry flop.
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry   <= sub ? 1'b1 : cin;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          res_sr  <= {s_bit, res_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry   <= c_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            c_msb_in <= carry;
            state    <= DONE;
          end
        end
        DONE: begin
          sum   <= res_sr;
          cout  <= carry;
          ovf   <= c_msb_in ^ carry;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
